pulse_generator: RTL

PULSE_GENERATOR -- requirements
Module: pulse_generator

---
 rtl/pulse_gen_pkg.sv | 20 ++
 rtl/pulse_timer.sv | 43 ++++
 rtl/pulse_generator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// pulse_gen_pkg
// Shared definitions for the pulse generator:
//   - CNT_W_DEFAULT : default width of the high/low cycle operands and timer
//   - PCNT_W        : width of the pulse_count operand
//   - pg_state_e    : FSM state encoding (IDLE / HIGH / LOW)
// Optional feature macro used by the importing files: PULSE_GEN_BURST_EN.
// -----------------------------------------------------------------------------
package pulse_gen_pkg;

  localparam int CNT_W_DEFAULT = 32;
  localparam int PCNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pg_state_e;

endpackage : pulse_gen_pkg

// File: rtl/pulse_timer.sv
// -----------------------------------------------------------------------------
// pulse_timer
// Loadable CNT_W-bit down-counter shared by the HIGH and LOW phases.
// A load presets the count to the phase length N; every enabled cycle then
// counts down, and expire flags the last cycle of the phase (count == 1), so a
// phase of N cycles lasts exactly N cycles and N = 2^CNT_W-1 never wraps.
// Ports:
//   sys_clk  in   clock (rising edge)
//   reset    in   asynchronous active-low reset, clears the count
//   load     in   preset the count to value (has priority over enable)
//   value    in   CNT_W phase length
//   enable   in   count down this cycle
//   expire   out  enabled and in the final cycle of the phase
// -----------------------------------------------------------------------------
module pulse_timer
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             enable,
  output logic             expire
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (enable && (count_reg != '0)) begin
      // Saturate at zero so a stray enable can never wrap the counter.
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign expire = enable && (count_reg == CNT_W'(1));

endmodule : pulse_timer

// File: rtl/pulse_generator.sv
// -----------------------------------------------------------------------------
// pulse_generator
// Generates a registered pulse of high_cycles sys_clk cycles on request.
// With macro PULSE_GEN_BURST_EN defined it generates a burst of pulse_count
// pulses (0 treated as 1) separated by low_cycles-long gaps; a zero gap gives
// back-to-back HIGH phases with signal_out held high throughout.
// Operands are captured at acceptance; abort returns to IDLE without a done.
// Ports:
//   sys_clk      in   clock (rising edge)
//   reset        in   asynchronous active-low reset
//   start_valid  in   request
//   start_ready  out  idle and not aborting; handshake = valid && ready
//   high_cycles  in   CNT_W pulse high time
//   low_cycles   in   CNT_W gap between burst pulses (burst build only)
//   pulse_count  in   16-bit pulses per burst (burst build only)
//   abort        in   terminate current operation
//   signal_out   out  generated pulse (registered)
//   busy         out  FSM not in IDLE
//   done         out  one-cycle completion strobe (registered)
// -----------------------------------------------------------------------------
module pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [CNT_W-1:0]  high_cycles,
  input  logic [CNT_W-1:0]  low_cycles,
  input  logic [PCNT_W-1:0] pulse_count,
  input  logic              abort,
  output logic              signal_out,
  output logic              busy,
  output logic              done
);

  pg_state_e        state_reg, state_next;
  logic             done_next;
  logic             accept;

  logic             timer_load;
  logic             timer_enable;
  logic [CNT_W-1:0] timer_value;
  logic             timer_expire;

  assign start_ready = (state_reg == IDLE) && !abort;
  assign accept      = start_valid && start_ready;
  assign busy        = (state_reg != IDLE);

  // ---------------------------------------------------------------------------
  // Burst bookkeeping: operands latched at acceptance plus the pulse counter.
  // ---------------------------------------------------------------------------
`ifdef PULSE_GEN_BURST_EN
  logic [CNT_W-1:0]  high_reg;
  logic [CNT_W-1:0]  low_reg;
  logic [PCNT_W-1:0] pulses_left_reg, pulses_left_next;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      high_reg        <= '0;
      low_reg         <= '0;
      pulses_left_reg <= '0;
    end else begin
      if (accept) begin
        high_reg <= high_cycles;
        low_reg  <= low_cycles;
      end
      pulses_left_reg <= pulses_left_next;
    end
  end
`else
  // Single-pulse build: the gap and count operands are intentionally ignored.
  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{low_cycles, pulse_count};
`endif

  // ---------------------------------------------------------------------------
  // Shared phase timer. The high time is loaded straight from the input at
  // acceptance, which is what makes later input changes irrelevant.
  // ---------------------------------------------------------------------------
  pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .sys_clk (sys_clk),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .enable  (timer_enable),
    .expire  (timer_expire)
  );

  // ---------------------------------------------------------------------------
  // FSM state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      signal_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      // Registering the next-state decode makes signal_out rise on the
      // accepting edge and fall on the edge that leaves HIGH.
      signal_out <= (state_next == HIGH);
      done       <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    done_next    = 1'b0;
    timer_load   = 1'b0;
    timer_enable = 1'b0;
    timer_value  = '0;
`ifdef PULSE_GEN_BURST_EN
    pulses_left_next = pulses_left_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
`ifdef PULSE_GEN_BURST_EN
          pulses_left_next = (pulse_count == '0) ? PCNT_W'(1) : pulse_count;
`endif
          if (high_cycles == '0) begin
            // Zero-width request: nothing to drive, just report completion.
            done_next = 1'b1;
          end else begin
            state_next  = HIGH;
            timer_load  = 1'b1;
            timer_value = high_cycles;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          timer_enable = 1'b1;
          if (timer_expire) begin
`ifdef PULSE_GEN_BURST_EN
            if (pulses_left_reg <= PCNT_W'(1)) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              pulses_left_next = pulses_left_reg - PCNT_W'(1);
              timer_load       = 1'b1;
              if (low_reg == '0) begin
                // No gap: restart the high phase without leaving HIGH.
                timer_value = high_reg;
              end else begin
                state_next  = LOW;
                timer_value = low_reg;
              end
            end
`else
            state_next = IDLE;
            done_next  = 1'b1;
`endif
          end
        end
      end

      LOW: begin
`ifdef PULSE_GEN_BURST_EN
        if (abort) begin
          state_next = IDLE;
        end else begin
          timer_enable = 1'b1;
          if (timer_expire) begin
            state_next  = HIGH;
            timer_load  = 1'b1;
            timer_value = high_reg;
          end
        end
`else
        // Unreachable in the single-pulse build.
        state_next = IDLE;
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule : pulse_generator
